// File: rtl/decode_stage.sv
// Decode stage: register file with writeback bypass, RV32I immediate
// generation, load-use hazard detection and an ID/EX output register.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [IDX_W-1:0] out_rd,
    output logic [IDX_W-1:0] out_rs1_idx,
    output logic [IDX_W-1:0] out_rs2_idx,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_is_load,
    output logic             out_illegal
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    logic [XLEN-1:0]  regs [NREGS];

    logic [6:0]       dec_opcode;
    logic [2:0]       dec_funct3;
    logic [6:0]       dec_funct7;
    logic [IDX_W-1:0] dec_rd;
    logic [IDX_W-1:0] dec_rs1;
    logic [IDX_W-1:0] dec_rs2;
    logic [XLEN-1:0]  dec_rs1_val;
    logic [XLEN-1:0]  dec_rs2_val;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_is_load;
    logic             dec_illegal;

    logic             free;
    logic             hazard;

    // Field extraction; register indices are truncated to IDX_W bits.
    always_comb begin
        dec_opcode = in_instr[6:0];
        dec_funct3 = in_instr[14:12];
        dec_funct7 = in_instr[31:25];
        dec_rd     = IDX_W'(in_instr[11:7]);
        dec_rs1    = IDX_W'(in_instr[19:15]);
        dec_rs2    = IDX_W'(in_instr[24:20]);
    end

    // Register file read with same-cycle writeback bypass.
    always_comb begin
        dec_rs1_val = regs[dec_rs1];
        dec_rs2_val = regs[dec_rs2];
        if (wb_en && (wb_idx == dec_rs1)) begin
            dec_rs1_val = wb_data;
        end
        if (wb_en && (wb_idx == dec_rs2)) begin
            dec_rs2_val = wb_data;
        end
        if (dec_rs1 == '0) begin
            dec_rs1_val = '0;
        end
        if (dec_rs2 == '0) begin
            dec_rs2_val = '0;
        end
    end

    // Immediates are formed at 32 bits, then sign-extended to XLEN.
    always_comb begin
        imm32       = '0;
        dec_is_load = 1'b0;
        dec_illegal = 1'b0;
        case (dec_opcode)
            OPC_LOAD: begin
                imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_is_load = 1'b1;
            end
            OPC_OPIMM, OPC_JALR: begin
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_OP: begin
                imm32 = '0;
            end
            default: begin
                imm32       = '0;
                dec_illegal = 1'b1;
            end
        endcase
        dec_imm = XLEN'(imm32);
    end

    // Hazard compare ignores whether the incoming opcode uses rs1/rs2.
    always_comb begin
        free     = !out_valid || out_ready;
        hazard   = out_valid && out_is_load && (out_rd != '0) &&
                   ((out_rd == dec_rs1) || (out_rd == dec_rs2));
        in_ready = free && !hazard && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_idx != '0)) begin
            regs[wb_idx] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_rd      <= '0;
            out_rs1_idx <= '0;
            out_rs2_idx <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_is_load <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (free) begin
            if (hazard || !in_valid) begin
                out_valid <= 1'b0;
            end else begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_opcode  <= dec_opcode;
                out_funct3  <= dec_funct3;
                out_funct7  <= dec_funct7;
                out_rd      <= dec_rd;
                out_rs1_idx <= dec_rs1;
                out_rs2_idx <= dec_rs2;
                out_rs1_val <= dec_rs1_val;
                out_rs2_val <= dec_rs2_val;
                out_imm     <= dec_imm;
                out_is_load <= dec_is_load;
                out_illegal <= dec_illegal;
            end
        end else begin
            // Held instruction picks up writebacks to its source registers.
            if (wb_en && (wb_idx != '0) && (wb_idx == out_rs1_idx)) begin
                out_rs1_val <= wb_data;
            end
            if (wb_en && (wb_idx != '0) && (wb_idx == out_rs2_idx)) begin
                out_rs2_val <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default 32x32 instance plus a 64-bit,
// 16-register instance for width and truncation checks.
module tb_decode_stage;

    localparam int unsigned AX = 32;
    localparam int unsigned AI = 5;
    localparam int unsigned BX = 64;
    localparam int unsigned BI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Instance A (XLEN=32, NREGS=32)
    logic          a_rst, a_in_valid, a_in_ready, a_flush, a_wb_en;
    logic [31:0]   a_in_instr;
    logic [AX-1:0] a_in_pc, a_wb_data;
    logic [AI-1:0] a_wb_idx;
    logic          a_out_valid, a_out_ready, a_out_is_load, a_out_illegal;
    logic [AX-1:0] a_out_pc, a_out_rs1_val, a_out_rs2_val, a_out_imm;
    logic [6:0]    a_out_opcode, a_out_funct7;
    logic [2:0]    a_out_funct3;
    logic [AI-1:0] a_out_rd, a_out_rs1_idx, a_out_rs2_idx;

    // Instance B (XLEN=64, NREGS=16)
    logic          b_rst, b_in_valid, b_in_ready, b_flush, b_wb_en;
    logic [31:0]   b_in_instr;
    logic [BX-1:0] b_in_pc, b_wb_data;
    logic [BI-1:0] b_wb_idx;
    logic          b_out_valid, b_out_ready, b_out_is_load, b_out_illegal;
    logic [BX-1:0] b_out_pc, b_out_rs1_val, b_out_rs2_val, b_out_imm;
    logic [6:0]    b_out_opcode, b_out_funct7;
    logic [2:0]    b_out_funct3;
    logic [BI-1:0] b_out_rd, b_out_rs1_idx, b_out_rs2_idx;

    decode_stage #(.XLEN(AX), .NREGS(32)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(a_flush),
        .wb_en(a_wb_en), .wb_idx(a_wb_idx), .wb_data(a_wb_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_opcode(a_out_opcode), .out_funct3(a_out_funct3),
        .out_funct7(a_out_funct7), .out_rd(a_out_rd),
        .out_rs1_idx(a_out_rs1_idx), .out_rs2_idx(a_out_rs2_idx),
        .out_rs1_val(a_out_rs1_val), .out_rs2_val(a_out_rs2_val),
        .out_imm(a_out_imm), .out_is_load(a_out_is_load),
        .out_illegal(a_out_illegal)
    );

    decode_stage #(.XLEN(BX), .NREGS(16)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush),
        .wb_en(b_wb_en), .wb_idx(b_wb_idx), .wb_data(b_wb_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_opcode(b_out_opcode), .out_funct3(b_out_funct3),
        .out_funct7(b_out_funct7), .out_rd(b_out_rd),
        .out_rs1_idx(b_out_rs1_idx), .out_rs2_idx(b_out_rs2_idx),
        .out_rs1_val(b_out_rs1_val), .out_rs2_val(b_out_rs2_val),
        .out_imm(b_out_imm), .out_is_load(b_out_is_load),
        .out_illegal(b_out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0;
        a_flush = 1'b0; a_wb_en = 1'b0; a_wb_idx = '0; a_wb_data = '0;
        a_out_ready = 1'b1;
        b_rst = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0;
        b_flush = 1'b0; b_wb_en = 1'b0; b_wb_idx = '0; b_wb_data = '0;
        b_out_ready = 1'b1;

        tick();
        check("reset_out_valid", 64'(a_out_valid), 64'd0);
        check("reset_out_imm", 64'(a_out_imm), 64'd0);
        check("reset_out_pc", 64'(a_out_pc), 64'd0);
        check("reset_in_ready", 64'(a_in_ready), 64'd1);
        a_rst = 1'b1;
        b_rst = 1'b1;
        tick();

        // ADDI x1,x0,-5
        a_in_valid = 1'b1; a_in_instr = 32'hFFB00093; a_in_pc = 32'h100;
        tick();
        check("addi_valid", 64'(a_out_valid), 64'd1);
        check("addi_imm", 64'(a_out_imm), 64'hFFFFFFFB);
        check("addi_rd", 64'(a_out_rd), 64'd1);
        check("addi_illegal", 64'(a_out_illegal), 64'd0);
        check("addi_pc", 64'(a_out_pc), 64'h100);
        check("addi_opcode", 64'(a_out_opcode), 64'h13);

        // ADD x6,x5,x5 with x5=0x1234 written the same cycle
        a_in_instr = 32'h00528333; a_in_pc = 32'h104;
        a_wb_en = 1'b1; a_wb_idx = 5'd5; a_wb_data = 32'h1234;
        tick();
        check("bypass_rs1", 64'(a_out_rs1_val), 64'h1234);
        check("bypass_rs2", 64'(a_out_rs2_val), 64'h1234);
        check("add_imm", 64'(a_out_imm), 64'd0);
        check("add_rd", 64'(a_out_rd), 64'd6);

        // ADD x7,x0,x5 while writing 0xDEAD to x0
        a_in_instr = 32'h005003B3;
        a_wb_idx = 5'd0; a_wb_data = 32'hDEAD;
        tick();
        check("x0_bypass_blocked", 64'(a_out_rs1_val), 64'd0);
        check("x5_stored", 64'(a_out_rs2_val), 64'h1234);

        // ADD x8,x0,x0 after the x0 write
        a_wb_en = 1'b0;
        a_in_instr = 32'h00000433;
        tick();
        check("x0_reads_zero", 64'(a_out_rs1_val), 64'd0);

        // ADD x3,x7,x0 captured, then held while x7 is written
        a_in_instr = 32'h000381B3;
        tick();
        check("hold_capture_rd", 64'(a_out_rd), 64'd3);
        a_out_ready = 1'b0;
        a_in_instr = 32'h00100493;
        a_wb_en = 1'b1; a_wb_idx = 5'd7; a_wb_data = 32'h55;
        #1;
        check("hold_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        a_wb_en = 1'b0;
        #1;
        check("hold_refresh_rs1", 64'(a_out_rs1_val), 64'h55);
        check("hold_rd_frozen", 64'(a_out_rd), 64'd3);
        check("hold_valid", 64'(a_out_valid), 64'd1);
        check("hold_in_ready2", 64'(a_in_ready), 64'd0);
        a_out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        check("after_hold_rd", 64'(a_out_rd), 64'd9);
        check("after_hold_imm", 64'(a_out_imm), 64'd1);

        // LW x4,0(x2) then dependent ADD x5,x4,x1
        a_in_instr = 32'h00012203;
        tick();
        check("lw_is_load", 64'(a_out_is_load), 64'd1);
        check("lw_rd", 64'(a_out_rd), 64'd4);
        a_in_instr = 32'h00012303;
        #1;
        check("lw_lw_no_stall", 64'(a_in_ready), 64'd1);
        a_in_instr = 32'h001202B3;
        #1;
        check("load_use_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        check("bubble_valid", 64'(a_out_valid), 64'd0);
        check("bubble_rd_kept", 64'(a_out_rd), 64'd4);
        check("after_bubble_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        check("dep_add_valid", 64'(a_out_valid), 64'd1);
        check("dep_add_rd", 64'(a_out_rd), 64'd5);
        check("dep_add_not_load", 64'(a_out_is_load), 64'd0);

        // Flush with a held instruction and a concurrent write to x10
        a_out_ready = 1'b0;
        a_in_instr = 32'h00100493;
        a_flush = 1'b1;
        a_wb_en = 1'b1; a_wb_idx = 5'd10; a_wb_data = 32'hBEEF;
        #1;
        check("flush_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        check("flush_valid", 64'(a_out_valid), 64'd0);
        check("flush_rd_kept", 64'(a_out_rd), 64'd5);
        a_flush = 1'b0; a_wb_en = 1'b0; a_out_ready = 1'b1;
        a_in_instr = 32'h000505B3;
        tick();
        check("flush_wb_visible", 64'(a_out_rs1_val), 64'hBEEF);
        check("post_flush_rd", 64'(a_out_rd), 64'd11);

        // Reset while held drops the instruction and clears the register file
        a_out_ready = 1'b0;
        a_rst = 1'b0;
        #1;
        check("midreset_valid", 64'(a_out_valid), 64'd0);
        check("midreset_rs1_val", 64'(a_out_rs1_val), 64'd0);
        tick();
        a_rst = 1'b1; a_out_ready = 1'b1;
        tick();
        check("midreset_x10_cleared", 64'(a_out_rs1_val), 64'd0);

        // XLEN=64 / NREGS=16 instance
        b_in_valid = 1'b1; b_in_instr = 32'hFE000EE3; b_in_pc = 64'h8000_0000_0000_0010;
        tick();
        check("b_beq_imm", b_out_imm, 64'hFFFFFFFFFFFFFFFC);
        check("b_beq_pc", b_out_pc, 64'h8000_0000_0000_0010);
        check("b_beq_illegal", 64'(b_out_illegal), 64'd0);
        b_in_instr = 32'h0010006F;
        tick();
        check("b_jal_imm", b_out_imm, 64'h800);
        b_in_instr = 32'h0000007F;
        tick();
        check("b_illegal", 64'(b_out_illegal), 64'd1);
        check("b_illegal_imm", b_out_imm, 64'd0);
        b_in_instr = 32'h00000893;
        tick();
        check("b_rd_truncated", 64'(b_out_rd), 64'd1);
        check("b_valid", 64'(b_out_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
